cplx_delay_line: RTL and testbench
==================================

CPLX_DELAY_LINE -- requirements
Module: cplx_delay_line

Interface
REQ-001 Parameter DATA_W, default 16: width of the real part and of the imaginary part, each two's-complement.
REQ-002 Parameter DEPTH, default 4: number of delay stages; legal range 1..1024.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 en  input  1  shift enable; stages advance only on cycles with en=1.
REQ-006 flush  input  1  synchronous clear of all stages and valid bits.
REQ-007 in_valid  input  1  qualifier captured alongside in_r/in_i.
REQ-008 in_r  input  DATA_W  real sample in.
REQ-009 in_i  input  DATA_W  imaginary sample in.
REQ-010 out_r  output  DATA_W  real sample from the oldest stage (tap 0).
REQ-011 out_i  output  DATA_W  imaginary sample from tap 0.
REQ-012 out_valid  output  1  valid bit held in tap 0.
REQ-013 primed  output  1  high once DEPTH enabled shifts have occurred since the last reset or flush.
REQ-014 fill_cnt  output  $clog2(DEPTH+1)  enabled-shift count, saturating at DEPTH (present only under CDL_FILL_EN).

Function
REQ-015 Each stage SHALL hold {valid, real, imag}; on en=1 and flush=0, stage DEPTH-1 SHALL load {in_valid, in_r, in_i} and stage k SHALL load stage k+1 for k<DEPTH-1.
REQ-016 On en=0 and flush=0, all stages, valid bits and the shift counter SHALL hold their values.
REQ-017 Latency: a sample presented with en=1 SHALL appear on out_r/out_i/out_valid after exactly DEPTH enabled shifts, independent of the number of en=0 cycles in between.
REQ-018 Outputs SHALL be driven directly from tap-0 registers with no combinational path from any input.
REQ-019 Data SHALL be passed bit-exact, with no rounding, sign change or width change.
REQ-020 The internal shift counter SHALL increment on each enabled shift and saturate at DEPTH; primed SHALL be 1 exactly when the counter equals DEPTH.
REQ-021 flush=1 SHALL, on the next edge, zero every stage, valid bit and the counter; flush SHALL take priority over en.
REQ-022 Simultaneous flush=1 and en=1: the input sample SHALL be discarded, not captured.
REQ-023 DEPTH=1: the block SHALL act as a single enabled register; primed SHALL assert after the first enabled shift.
REQ-024 out_valid SHALL reflect only the in_valid bit carried with that sample; it SHALL be independent of primed.

Reset
REQ-025 rst=1 SHALL asynchronously force all stages, valid bits and the counter to 0, giving out_r=0, out_i=0, out_valid=0 and primed=0 (fill_cnt=0 when present).
REQ-026 Asserting rst mid-operation SHALL discard all in-flight samples; after release, the next sample SHALL again need DEPTH enabled shifts to emerge.
REQ-027 rst SHALL override flush and en.

Configuration
REQ-028 Macro CDL_FILL_EN defined: the fill_cnt port SHALL exist and show the saturating counter value.
REQ-029 CDL_FILL_EN undefined: the fill_cnt port SHALL be absent; primed and all other behaviour SHALL be identical.

Verification
REQ-030 DEPTH=4, en=1 constantly, feed in_r=1..8, in_i=-1..-8, in_valid=1 -> out_r=1 and out_i=-1 after 4 edges, then one sample per cycle; primed rises on the 4th edge.
REQ-031 DEPTH=4, feed samples 10,20,30,40 with en toggling 1,0,1,0,... -> out sequence 10,20,30,40 emerges only after enabled edges; held values unchanged on en=0 cycles.
REQ-032 Fill with 4 samples, then flush=1 together with en=1 and in_r=99 -> next cycle out_r=0, out_valid=0, primed=0, and 99 never appears.
REQ-033 in_valid pattern 1,0,1,1 with en=1 -> out_valid pattern 1,0,1,1 starting 4 edges later.
REQ-034 Assert rst asynchronously between edges mid-stream -> outputs go 0 immediately; after release, first new sample appears after 4 enabled edges.
REQ-035 DEPTH=1 with CDL_FILL_EN -> 1-cycle latency; fill_cnt goes 0->1 and saturates; build without the macro passes the same data checks.

Source files
------------

// File: rtl/cplx_delay_line.sv
// Complex-sample delay line: DEPTH enabled shifts from input to tap 0, valid bit carried per stage.
// Optional fill counter port is exposed when CDL_FILL_EN is defined.
module cplx_delay_line #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_i,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_i,
  output logic              out_valid,
  output logic              primed
`ifdef CDL_FILL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] fill_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic [DATA_W-1:0] re_r [DEPTH];
  logic [DATA_W-1:0] im_r [DEPTH];
  logic              vld_r [DEPTH];
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              primed_r;

  // Next fill count: cleared by flush, saturating increment on enabled shifts.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (flush) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (en && (cnt_r != CNT_FULL)) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Stage storage and fill tracking; primed is registered from the next count so it tracks cnt_r exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        re_r[k]  <= DATA_ZERO;
        im_r[k]  <= DATA_ZERO;
        vld_r[k] <= 1'b0;
      end
      cnt_r    <= CNT_ZERO;
      primed_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      primed_r <= (cnt_nxt_s == CNT_FULL);
      if (flush) begin
        for (int k = 0; k < DEPTH; k++) begin
          re_r[k]  <= DATA_ZERO;
          im_r[k]  <= DATA_ZERO;
          vld_r[k] <= 1'b0;
        end
      end else if (en) begin
        for (int k = 0; k < DEPTH - 1; k++) begin
          re_r[k]  <= re_r[k+1];
          im_r[k]  <= im_r[k+1];
          vld_r[k] <= vld_r[k+1];
        end
        re_r[DEPTH-1]  <= in_r;
        im_r[DEPTH-1]  <= in_i;
        vld_r[DEPTH-1] <= in_valid;
      end
    end
  end

  assign out_r     = re_r[0];
  assign out_i     = im_r[0];
  assign out_valid = vld_r[0];
  assign primed    = primed_r;
`ifdef CDL_FILL_EN
  assign fill_cnt  = cnt_r;
`endif

endmodule

// File: tb/tb_cplx_delay_line.sv
// Self-checking bench for cplx_delay_line: DEPTH=4 and DEPTH=1 instances share stimulus,
// each checked against a queue scoreboard, plus table vectors and hand sequences.
module tb_cplx_delay_line;

  logic        clk = 1'b0;
  logic        rst, en, flush, in_valid;
  logic [15:0] in_r, in_i;
  logic [15:0] out_r, out_i, d1_out_r, d1_out_i;
  logic        out_valid, primed, d1_out_valid, d1_primed;
`ifdef CDL_FILL_EN
  logic [2:0]  fill_cnt;
  logic [0:0]  d1_fill_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [32:0] q4[$];
  logic [32:0] q1[$];
  int          cnt4, cnt1;

  always #5 clk = ~clk;

  cplx_delay_line #(.DATA_W(16), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
    .in_r(in_r), .in_i(in_i), .out_r(out_r), .out_i(out_i),
    .out_valid(out_valid), .primed(primed)
`ifdef CDL_FILL_EN
    , .fill_cnt(fill_cnt)
`endif
  );

  cplx_delay_line #(.DATA_W(16), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
    .in_r(in_r), .in_i(in_i), .out_r(d1_out_r), .out_i(d1_out_i),
    .out_valid(d1_out_valid), .primed(d1_primed)
`ifdef CDL_FILL_EN
    , .fill_cnt(d1_fill_cnt)
`endif
  );

  typedef struct {
    logic        e;
    logic        v;
    logic [15:0] r;
    logic [15:0] i;
    logic [15:0] xr;
    logic [15:0] xi;
    logic        xv;
    logic        xp;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q4.delete();
    q1.delete();
    repeat (4) q4.push_back(33'd0);
    q1.push_back(33'd0);
    cnt4 = 0;
    cnt1 = 0;
  endtask

  task automatic compare_all();
    logic [32:0] e4, e1;
    e4 = q4[0];
    e1 = q1[0];
    chk("d4_out_r", out_r, e4[31:16]);
    chk("d4_out_i", out_i, e4[15:0]);
    chk("d4_out_valid", out_valid, e4[32]);
    chk("d4_primed", primed, cnt4 == 4);
    chk("d1_out_r", d1_out_r, e1[31:16]);
    chk("d1_out_i", d1_out_i, e1[15:0]);
    chk("d1_out_valid", d1_out_valid, e1[32]);
    chk("d1_primed", d1_primed, cnt1 == 1);
`ifdef CDL_FILL_EN
    chk("d4_fill_cnt", fill_cnt, cnt4);
    chk("d1_fill_cnt", d1_fill_cnt, cnt1);
`endif
  endtask

  // Drive one cycle, advance the scoreboards, then compare just after the edge.
  task automatic step(input logic e, input logic f, input logic v,
                      input logic [15:0] r, input logic [15:0] i);
    en = e; flush = f; in_valid = v; in_r = r; in_i = i;
    @(posedge clk);
    #1;
    if (f) begin
      model_clear();
    end else if (e) begin
      q4.push_back({v, r, i});
      void'(q4.pop_front());
      q1.push_back({v, r, i});
      void'(q1.pop_front());
      if (cnt4 < 4) cnt4++;
      if (cnt1 < 1) cnt1++;
    end
    compare_all();
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      tbl[k].e  = 1'b1;
      tbl[k].v  = 1'b1;
      tbl[k].r  = 16'(k + 1);
      tbl[k].i  = 16'(-(k + 1));
      tbl[k].xr = (k >= 3) ? 16'(k - 2) : 16'd0;
      tbl[k].xi = (k >= 3) ? 16'(-(k - 2)) : 16'd0;
      tbl[k].xv = (k >= 3);
      tbl[k].xp = (k >= 3);
    end

    rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_r = 16'd0; in_i = 16'd0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_out_r", out_r, 16'd0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_primed", primed, 1'b0);
    compare_all();
    rst = 1'b0;

    // Ramp 1..8 / -1..-8 with constant enable
    for (int k = 0; k < 8; k++) begin
      step(tbl[k].e, 1'b0, tbl[k].v, tbl[k].r, tbl[k].i);
      chk("tbl_out_r", out_r, tbl[k].xr);
      chk("tbl_out_i", out_i, tbl[k].xi);
      chk("tbl_out_valid", out_valid, tbl[k].xv);
      chk("tbl_primed", primed, tbl[k].xp);
    end

    // Toggled enable: disabled-cycle inputs must not be captured
    step(1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
    chk("flush_primed", primed, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'd10, 16'd1);
    step(1'b0, 1'b0, 1'b1, 16'd77, 16'd77);
    step(1'b1, 1'b0, 1'b1, 16'd20, 16'd2);
    step(1'b0, 1'b0, 1'b1, 16'd77, 16'd77);
    step(1'b1, 1'b0, 1'b1, 16'd30, 16'd3);
    step(1'b0, 1'b0, 1'b1, 16'd77, 16'd77);
    chk("toggle_not_yet", out_r, 16'd0);
    step(1'b1, 1'b0, 1'b1, 16'd40, 16'd4);
    chk("toggle_first", out_r, 16'd10);
    step(1'b0, 1'b0, 1'b0, 16'd77, 16'd77);
    chk("toggle_hold", out_r, 16'd10);
    step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    chk("toggle_second", out_r, 16'd20);
    step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    chk("toggle_fourth", out_r, 16'd40);

    // Fill then flush together with enable: 99 is discarded
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1, 16'(50 + k), 16'(60 + k));
    chk("fill_primed", primed, 1'b1);
    step(1'b1, 1'b1, 1'b1, 16'd99, 16'd99);
    chk("flush_out_r", out_r, 16'd0);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_primed2", primed, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
      chk("no_99", out_r != 16'd99, 1'b1);
    end

    // Valid pattern 1,0,1,1 carried with data
    step(1'b1, 1'b0, 1'b1, 16'd1, 16'd1);
    step(1'b1, 1'b0, 1'b0, 16'd2, 16'd2);
    step(1'b1, 1'b0, 1'b1, 16'd3, 16'd3);
    step(1'b1, 1'b0, 1'b1, 16'd4, 16'd4);
    chk("vpat0", out_valid, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    chk("vpat1", out_valid, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    chk("vpat2", out_valid, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    chk("vpat3", out_valid, 1'b1);

    // Asynchronous reset between edges mid-stream
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1, 16'(200 + k), 16'(300 + k));
    #3;
    rst = 1'b1;
    #1;
    chk("async_out_r", out_r, 16'd0);
    chk("async_out_i", out_i, 16'd0);
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_primed", primed, 1'b0);
    chk("async_d1_out_r", d1_out_r, 16'd0);
    model_clear();
    #2;
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b1, 16'd55, 16'd66);
    chk("d1_latency", d1_out_r, 16'd55);
    step(1'b1, 1'b0, 1'b0, 16'd1, 16'd1);
    step(1'b0, 1'b0, 1'b0, 16'd9, 16'd9);
    step(1'b1, 1'b0, 1'b0, 16'd2, 16'd2);
    chk("post_rst_not_yet", out_r, 16'd0);
    step(1'b1, 1'b0, 1'b0, 16'd3, 16'd3);
    chk("post_rst_first", out_r, 16'd55);
    chk("post_rst_first_i", out_i, 16'd66);

    // Random traffic against the scoreboards
    for (int k = 0; k < 60; k++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom), 16'($urandom), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
